// File: rtl/riscv_pkg.sv
// Shared constants for the RISC-V core pipeline stages.
package riscv_pkg;

  localparam int unsigned XLEN_DEF     = 64;
  localparam int unsigned ILEN_DEF     = 32;
  localparam int unsigned PC_INCREMENT = 4;

  // addi x0, x0, 0 -- canonical bubble placed in IF/ID on reset and flush
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage : riscv_pkg

// File: rtl/if_id_register.sv
// IF/ID pipeline register with synchronous reset, flush (bubble insert) and hold.
module if_id_register
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned ILEN = ILEN_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_flush,
  input  logic            i_hold,
  input  logic [XLEN-1:0] i_pc,
  input  logic [ILEN-1:0] i_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [ILEN-1:0] o_instr,
  output logic            o_valid
);

  localparam logic [ILEN-1:0] NOP_W = ILEN'(NOP_INSTR);

  logic [XLEN-1:0] r_pc;
  logic [ILEN-1:0] r_instr;
  logic            r_valid;

  // Flush outranks hold: a wrong-path word is dropped even while decode stalls.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_pc    <= '0;
      r_instr <= NOP_W;
      r_valid <= 1'b0;
    end else if (!i_hold) begin
      r_pc    <= i_pc;
      r_instr <= i_instr;
      r_valid <= 1'b1;
    end
  end

  assign o_pc    = r_pc;
  assign o_instr = r_instr;
  assign o_valid = r_valid;

endmodule : if_id_register

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, next-PC selection, IF/ID capture and delivered-instruction count.
module instruction_fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter int unsigned     ILEN     = ILEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] Inst_Address,
  input  logic [ILEN-1:0] Instruction,
  output logic [XLEN-1:0] if_id_pc,
  output logic [ILEN-1:0] if_id_instruction,
  output logic            if_id_valid,
  output logic [XLEN-1:0] fetch_count
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_fetch_count;
  logic [XLEN-1:0] w_next_pc;
  logic [XLEN-1:0] w_target;
  logic            w_load;

  // Redirect targets are forced word-aligned.
  assign w_target = branch_target & ~XLEN'(2'b11);

  // A fresh, valid word enters IF/ID only when neither redirect nor stall is active.
  assign w_load = !branch_taken && !stall;

  always_comb begin
    w_next_pc = r_pc + XLEN'(PC_INCREMENT);
    if (branch_taken) begin
      w_next_pc = w_target;
    end else if (stall) begin
      w_next_pc = r_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_count <= '0;
    end else if (w_load) begin
      r_fetch_count <= r_fetch_count + XLEN'(1);
    end
  end

  if_id_register #(
    .XLEN (XLEN),
    .ILEN (ILEN)
  ) u_if_id (
    .clk     (clk),
    .reset   (reset),
    .i_flush (branch_taken),
    .i_hold  (stall),
    .i_pc    (r_pc),
    .i_instr (Instruction),
    .o_pc    (if_id_pc),
    .o_instr (if_id_instruction),
    .o_valid (if_id_valid)
  );

  assign Inst_Address = r_pc;
  assign fetch_count  = r_fetch_count;

endmodule : instruction_fetch_unit

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus randomized run vs. a reference model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken;
  logic [63:0] branch_target;
  logic [63:0] inst_address, if_id_pc, fetch_count;
  logic [31:0] instruction, if_id_instruction;
  logic        if_id_valid;

  logic [63:0] w_inst_address, w_if_id_pc, w_fetch_count;
  logic [31:0] w_instruction, w_if_id_instruction;
  logic        w_if_id_valid;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [63:0] m_pc, m_ipc, m_cnt;
  logic [31:0] m_iins;
  logic        m_ival;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [63:0] a);
    if (a == 64'h0) return 32'h0081_0093;
    return a[31:0] ^ 32'h5A5A_0033 ^ {a[63:48], 16'h0};
  endfunction

  assign instruction   = mem(inst_address);
  assign w_instruction = mem(w_inst_address);

  instruction_fetch_unit #(.XLEN(64), .ILEN(32), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .Inst_Address(inst_address),
    .Instruction(instruction), .if_id_pc(if_id_pc),
    .if_id_instruction(if_id_instruction), .if_id_valid(if_id_valid),
    .fetch_count(fetch_count)
  );

  instruction_fetch_unit #(.XLEN(64), .ILEN(32), .RESET_PC(WRAP_PC)) dut_w (
    .clk(clk), .reset(reset), .stall(1'b0), .branch_taken(1'b0),
    .branch_target(64'h0), .Inst_Address(w_inst_address),
    .Instruction(w_instruction), .if_id_pc(w_if_id_pc),
    .if_id_instruction(w_if_id_instruction), .if_id_valid(w_if_id_valid),
    .fetch_count(w_fetch_count)
  );

  // One clock: drive inputs, advance the model by the stated priority rules, return at the negedge.
  task automatic step(input logic r, input logic s, input logic b, input logic [63:0] t);
    reset = r; stall = s; branch_taken = b; branch_target = t;
    @(posedge clk);
    if (r) begin
      m_pc = 64'h0; m_ipc = 64'h0; m_iins = NOP; m_ival = 1'b0; m_cnt = 64'h0;
    end else if (b) begin
      m_ipc = 64'h0; m_iins = NOP; m_ival = 1'b0;
      m_pc = {t[63:2], 2'b00};
    end else if (!s) begin
      m_ipc = m_pc; m_iins = mem(m_pc); m_ival = 1'b1;
      m_cnt = m_cnt + 64'd1;
      m_pc = m_pc + 64'd4;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 64'h0);
    step(1'b1, 1'b1, 1'b1, 64'h80);
    n_cmp++; if (inst_address !== 64'h0) begin n_bad++; $display("FAIL reset_addr got=%h exp=%h", inst_address, 64'h0); end
    n_cmp++; if (if_id_pc !== 64'h0) begin n_bad++; $display("FAIL reset_ifid_pc got=%h exp=%h", if_id_pc, 64'h0); end
    n_cmp++; if (if_id_instruction !== NOP) begin n_bad++; $display("FAIL reset_instr got=%h exp=%h", if_id_instruction, NOP); end
    n_cmp++; if (if_id_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", if_id_valid); end
    n_cmp++; if (fetch_count !== 64'h0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
  endtask

  task automatic test_free_run();
    step(1'b1, 1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b0, 1'b0, 64'h0);
    n_cmp++; if (inst_address !== 64'h4) begin n_bad++; $display("FAIL first_addr got=%h exp=4", inst_address); end
    n_cmp++; if (if_id_pc !== 64'h0) begin n_bad++; $display("FAIL first_pc got=%h exp=0", if_id_pc); end
    n_cmp++; if (if_id_instruction !== 32'h0081_0093) begin n_bad++; $display("FAIL first_instr got=%h exp=00810093", if_id_instruction); end
    n_cmp++; if (if_id_valid !== 1'b1) begin n_bad++; $display("FAIL first_valid got=%b exp=1", if_id_valid); end
    n_cmp++; if (fetch_count !== 64'd1) begin n_bad++; $display("FAIL first_count got=%0d exp=1", fetch_count); end
    for (int i = 2; i <= 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 64'h0);
      n_cmp++; if (inst_address !== 64'(4 * i)) begin n_bad++; $display("FAIL run_addr[%0d] got=%h exp=%h", i, inst_address, 64'(4 * i)); end
      n_cmp++; if (if_id_pc !== 64'(4 * (i - 1))) begin n_bad++; $display("FAIL run_pc[%0d] got=%h exp=%h", i, if_id_pc, 64'(4 * (i - 1))); end
    end
    n_cmp++; if (fetch_count !== 64'd5) begin n_bad++; $display("FAIL run_count got=%0d exp=5", fetch_count); end
  endtask

  task automatic test_stall();
    step(1'b1, 1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b0, 1'b0, 64'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 64'h0);
      n_cmp++; if (inst_address !== 64'h8) begin n_bad++; $display("FAIL stall_addr[%0d] got=%h exp=8", i, inst_address); end
      n_cmp++; if (if_id_pc !== 64'h4 || if_id_valid !== 1'b1) begin n_bad++; $display("FAIL stall_ifid[%0d] got=%h/%b exp=4/1", i, if_id_pc, if_id_valid); end
      n_cmp++; if (fetch_count !== 64'd2) begin n_bad++; $display("FAIL stall_count[%0d] got=%0d exp=2", i, fetch_count); end
    end
    step(1'b0, 1'b0, 1'b0, 64'h0);
    n_cmp++; if (if_id_pc !== 64'h8 || if_id_instruction !== mem(64'h8)) begin n_bad++; $display("FAIL stall_resume got=%h/%h exp=8/%h", if_id_pc, if_id_instruction, mem(64'h8)); end
    n_cmp++; if (inst_address !== 64'hC || fetch_count !== 64'd3) begin n_bad++; $display("FAIL stall_resume_cnt got=%h/%0d exp=c/3", inst_address, fetch_count); end
  endtask

  task automatic test_branch();
    step(1'b1, 1'b0, 1'b0, 64'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b0, 1'b1, 64'h40);
    n_cmp++; if (inst_address !== 64'h40) begin n_bad++; $display("FAIL br_addr got=%h exp=40", inst_address); end
    n_cmp++; if (if_id_valid !== 1'b0 || if_id_instruction !== NOP || if_id_pc !== 64'h0) begin n_bad++; $display("FAIL br_bubble got=%b/%h/%h exp=0/%h/0", if_id_valid, if_id_instruction, if_id_pc, NOP); end
    n_cmp++; if (fetch_count !== 64'd3) begin n_bad++; $display("FAIL br_count got=%0d exp=3", fetch_count); end
    step(1'b0, 1'b0, 1'b0, 64'h0);
    n_cmp++; if (if_id_pc !== 64'h40 || if_id_valid !== 1'b1 || if_id_instruction !== mem(64'h40)) begin n_bad++; $display("FAIL br_target got=%h/%b/%h exp=40/1/%h", if_id_pc, if_id_valid, if_id_instruction, mem(64'h40)); end
    n_cmp++; if (inst_address !== 64'h44) begin n_bad++; $display("FAIL br_next got=%h exp=44", inst_address); end
  endtask

  task automatic test_branch_stall();
    step(1'b0, 1'b1, 1'b1, 64'h43);
    n_cmp++; if (inst_address !== 64'h40) begin n_bad++; $display("FAIL brst_addr got=%h exp=40", inst_address); end
    n_cmp++; if (if_id_valid !== 1'b0 || if_id_instruction !== NOP || if_id_pc !== 64'h0) begin n_bad++; $display("FAIL brst_bubble got=%b/%h/%h exp=0/%h/0", if_id_valid, if_id_instruction, if_id_pc, NOP); end
    n_cmp++; if (fetch_count !== 64'd4) begin n_bad++; $display("FAIL brst_count got=%0d exp=4", fetch_count); end
  endtask

  task automatic test_wrap();
    step(1'b1, 1'b0, 1'b0, 64'h0);
    n_cmp++; if (w_inst_address !== WRAP_PC) begin n_bad++; $display("FAIL wrap_reset got=%h exp=%h", w_inst_address, WRAP_PC); end
    step(1'b0, 1'b0, 1'b0, 64'h0);
    n_cmp++; if (w_inst_address !== 64'h0) begin n_bad++; $display("FAIL wrap_pc got=%h exp=0", w_inst_address); end
    n_cmp++; if (w_if_id_pc !== WRAP_PC || w_if_id_instruction !== mem(WRAP_PC) || w_if_id_valid !== 1'b1) begin n_bad++; $display("FAIL wrap_ifid got=%h/%h/%b exp=%h/%h/1", w_if_id_pc, w_if_id_instruction, w_if_id_valid, WRAP_PC, mem(WRAP_PC)); end
    n_cmp++; if (w_fetch_count !== 64'd1) begin n_bad++; $display("FAIL wrap_count got=%0d exp=1", w_fetch_count); end
    // Redirect to the top word on the main instance, then fall through zero.
    step(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    n_cmp++; if (inst_address !== WRAP_PC) begin n_bad++; $display("FAIL wrap_br got=%h exp=%h", inst_address, WRAP_PC); end
    step(1'b0, 1'b0, 1'b0, 64'h0);
    n_cmp++; if (inst_address !== 64'h0 || if_id_pc !== WRAP_PC) begin n_bad++; $display("FAIL wrap_br_next got=%h/%h exp=0/%h", inst_address, if_id_pc, WRAP_PC); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b0, 1'b1, 64'h200);
    step(1'b0, 1'b0, 1'b0, 64'h0);
    step(1'b1, 1'b0, 1'b1, 64'h300);
    n_cmp++; if (inst_address !== 64'h0 || if_id_pc !== 64'h0 || if_id_instruction !== NOP || if_id_valid !== 1'b0 || fetch_count !== 64'h0) begin
      n_bad++; $display("FAIL mid_reset got=%h/%h/%h/%b/%0d exp=0/0/%h/0/0", inst_address, if_id_pc, if_id_instruction, if_id_valid, fetch_count, NOP);
    end
    n_cmp++; if (w_inst_address !== WRAP_PC || w_fetch_count !== 64'h0 || w_if_id_valid !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset_w got=%h/%0d/%b exp=%h/0/0", w_inst_address, w_fetch_count, w_if_id_valid, WRAP_PC);
    end
  endtask

  task automatic test_random();
    logic r, s, b;
    logic [63:0] t;
    step(1'b1, 1'b0, 1'b0, 64'h0);
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(99) < 2);
      s = ($urandom_range(99) < 30);
      b = ($urandom_range(99) < 12);
      t = {$urandom(), $urandom()};
      if ($urandom_range(3) == 0) t = {48'h0, 16'($urandom())};
      step(r, s, b, t);
      n_cmp++;
      if (inst_address !== m_pc || if_id_pc !== m_ipc || if_id_instruction !== m_iins ||
          if_id_valid !== m_ival || fetch_count !== m_cnt) begin
        n_bad++;
        $display("FAIL rand[%0d] got=%h/%h/%h/%b/%0d exp=%h/%h/%h/%b/%0d", i,
                 inst_address, if_id_pc, if_id_instruction, if_id_valid, fetch_count,
                 m_pc, m_ipc, m_iins, m_ival, m_cnt);
      end
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 64'h0;
    m_pc = 64'h0; m_ipc = 64'h0; m_iins = NOP; m_ival = 1'b0; m_cnt = 64'h0;
    test_reset();
    test_free_run();
    test_stall();
    test_branch();
    test_branch_stall();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_instruction_fetch_unit
